// File: rtl/svc_axi_stall_shim.sv
// AXI4 stall-injection shim: AR/AW/W pass straight through, while R and B are
// each held in a one-entry buffer whose release can be delayed by a bounded stall.
module svc_axi_stall_shim #(
  parameter int AXI_ADDR_WIDTH = 12,
  parameter int AXI_DATA_WIDTH = 128,
  parameter int AXI_ID_WIDTH   = 2,
  parameter int R_STALL_MAX    = 4,
  parameter int B_STALL_MAX    = 2
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        r_stall,
  input  logic                        b_stall,

  input  logic [AXI_ID_WIDTH-1:0]     s_axi_arid,
  input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]                  s_axi_arlen,
  input  logic [2:0]                  s_axi_arsize,
  input  logic [1:0]                  s_axi_arburst,
  input  logic                        s_axi_arlock,
  input  logic [3:0]                  s_axi_arcache,
  input  logic [2:0]                  s_axi_arprot,
  input  logic [3:0]                  s_axi_arqos,
  input  logic [3:0]                  s_axi_arregion,
  input  logic                        s_axi_arvalid,
  output logic                        s_axi_arready,

  input  logic [AXI_ID_WIDTH-1:0]     s_axi_awid,
  input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]                  s_axi_awlen,
  input  logic [2:0]                  s_axi_awsize,
  input  logic [1:0]                  s_axi_awburst,
  input  logic                        s_axi_awlock,
  input  logic [3:0]                  s_axi_awcache,
  input  logic [2:0]                  s_axi_awprot,
  input  logic [3:0]                  s_axi_awqos,
  input  logic [3:0]                  s_axi_awregion,
  input  logic                        s_axi_awvalid,
  output logic                        s_axi_awready,

  input  logic [AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                        s_axi_wlast,
  input  logic                        s_axi_wvalid,
  output logic                        s_axi_wready,

  output logic [AXI_ID_WIDTH-1:0]     s_axi_rid,
  output logic [AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]                  s_axi_rresp,
  output logic                        s_axi_rlast,
  output logic                        s_axi_rvalid,
  input  logic                        s_axi_rready,

  output logic [AXI_ID_WIDTH-1:0]     s_axi_bid,
  output logic [1:0]                  s_axi_bresp,
  output logic                        s_axi_bvalid,
  input  logic                        s_axi_bready,

  output logic [AXI_ID_WIDTH-1:0]     m_axi_arid,
  output logic [AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [7:0]                  m_axi_arlen,
  output logic [2:0]                  m_axi_arsize,
  output logic [1:0]                  m_axi_arburst,
  output logic                        m_axi_arlock,
  output logic [3:0]                  m_axi_arcache,
  output logic [2:0]                  m_axi_arprot,
  output logic [3:0]                  m_axi_arqos,
  output logic [3:0]                  m_axi_arregion,
  output logic                        m_axi_arvalid,
  input  logic                        m_axi_arready,

  output logic [AXI_ID_WIDTH-1:0]     m_axi_awid,
  output logic [AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]                  m_axi_awlen,
  output logic [2:0]                  m_axi_awsize,
  output logic [1:0]                  m_axi_awburst,
  output logic                        m_axi_awlock,
  output logic [3:0]                  m_axi_awcache,
  output logic [2:0]                  m_axi_awprot,
  output logic [3:0]                  m_axi_awqos,
  output logic [3:0]                  m_axi_awregion,
  output logic                        m_axi_awvalid,
  input  logic                        m_axi_awready,

  output logic [AXI_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                        m_axi_wlast,
  output logic                        m_axi_wvalid,
  input  logic                        m_axi_wready,

  input  logic [AXI_ID_WIDTH-1:0]     m_axi_rid,
  input  logic [AXI_DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]                  m_axi_rresp,
  input  logic                        m_axi_rlast,
  input  logic                        m_axi_rvalid,
  output logic                        m_axi_rready,

  input  logic [AXI_ID_WIDTH-1:0]     m_axi_bid,
  input  logic [1:0]                  m_axi_bresp,
  input  logic                        m_axi_bvalid,
  output logic                        m_axi_bready,

  output logic [1:0]                  r_state,
  output logic [1:0]                  b_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_SHOW = 2'd2
  } state_e;

  localparam int R_CW = $clog2(R_STALL_MAX + 1);
  localparam int B_CW = $clog2(B_STALL_MAX + 1);
  localparam logic [R_CW-1:0] R_MAX_C = R_CW'(R_STALL_MAX);
  localparam logic [R_CW-1:0] R_ONE_C = R_CW'(1);
  localparam logic [B_CW-1:0] B_MAX_C = B_CW'(B_STALL_MAX);
  localparam logic [B_CW-1:0] B_ONE_C = B_CW'(1);

  state_e                      r_state_q, r_state_d;
  logic   [R_CW-1:0]           r_cnt_q, r_cnt_d;
  logic                        r_load_s;
  logic   [AXI_ID_WIDTH-1:0]   r_id_q, r_id_d;
  logic   [AXI_DATA_WIDTH-1:0] r_data_q, r_data_d;
  logic   [1:0]                r_resp_q, r_resp_d;
  logic                        r_last_q, r_last_d;

  state_e                      b_state_q, b_state_d;
  logic   [B_CW-1:0]           b_cnt_q, b_cnt_d;
  logic                        b_load_s;
  logic   [AXI_ID_WIDTH-1:0]   b_id_q, b_id_d;
  logic   [1:0]                b_resp_q, b_resp_d;

  // Request and write-data channels are untouched wires in both directions.
  assign m_axi_arid     = s_axi_arid;
  assign m_axi_araddr   = s_axi_araddr;
  assign m_axi_arlen    = s_axi_arlen;
  assign m_axi_arsize   = s_axi_arsize;
  assign m_axi_arburst  = s_axi_arburst;
  assign m_axi_arlock   = s_axi_arlock;
  assign m_axi_arcache  = s_axi_arcache;
  assign m_axi_arprot   = s_axi_arprot;
  assign m_axi_arqos    = s_axi_arqos;
  assign m_axi_arregion = s_axi_arregion;
  assign m_axi_arvalid  = s_axi_arvalid;
  assign s_axi_arready  = m_axi_arready;

  assign m_axi_awid     = s_axi_awid;
  assign m_axi_awaddr   = s_axi_awaddr;
  assign m_axi_awlen    = s_axi_awlen;
  assign m_axi_awsize   = s_axi_awsize;
  assign m_axi_awburst  = s_axi_awburst;
  assign m_axi_awlock   = s_axi_awlock;
  assign m_axi_awcache  = s_axi_awcache;
  assign m_axi_awprot   = s_axi_awprot;
  assign m_axi_awqos    = s_axi_awqos;
  assign m_axi_awregion = s_axi_awregion;
  assign m_axi_awvalid  = s_axi_awvalid;
  assign s_axi_awready  = m_axi_awready;

  assign m_axi_wdata    = s_axi_wdata;
  assign m_axi_wstrb    = s_axi_wstrb;
  assign m_axi_wlast    = s_axi_wlast;
  assign m_axi_wvalid   = s_axi_wvalid;
  assign s_axi_wready   = m_axi_wready;

  assign s_axi_rid      = r_id_q;
  assign s_axi_rdata    = r_data_q;
  assign s_axi_rresp    = r_resp_q;
  assign s_axi_rlast    = r_last_q;
  assign s_axi_bid      = b_id_q;
  assign s_axi_bresp    = b_resp_q;
  assign r_state        = r_state_q;
  assign b_state        = b_state_q;

  // R: memory is only accepted while the buffer is empty or draining this cycle.
  always_comb begin
    r_state_d    = r_state_q;
    r_cnt_d      = r_cnt_q;
    r_load_s     = 1'b0;
    s_axi_rvalid = 1'b0;
    m_axi_rready = 1'b0;
    case (r_state_q)
      ST_IDLE: begin
        m_axi_rready = 1'b1;
        if (m_axi_rvalid) begin
          r_load_s  = 1'b1;
          r_state_d = ST_WAIT;
          r_cnt_d   = {R_CW{1'b0}};
        end else begin
          r_state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!r_stall || (r_cnt_q == R_MAX_C)) begin
          s_axi_rvalid = 1'b1;
          r_state_d    = s_axi_rready ? ST_IDLE : ST_SHOW;
        end else begin
          r_cnt_d = (r_cnt_q == R_MAX_C) ? r_cnt_q : r_cnt_q + R_ONE_C;
        end
      end
      ST_SHOW: begin
        s_axi_rvalid = 1'b1;
        m_axi_rready = s_axi_rready;
        if (s_axi_rready && m_axi_rvalid) begin
          r_load_s  = 1'b1;
          r_state_d = ST_WAIT;
          r_cnt_d   = {R_CW{1'b0}};
        end else if (s_axi_rready) begin
          r_state_d = ST_IDLE;
        end else begin
          r_state_d = ST_SHOW;
        end
      end
      default: begin
        r_state_d = ST_IDLE;
      end
    endcase
  end

  // R payload next value: refreshed only on capture.
  always_comb begin
    if (r_load_s) begin
      r_id_d   = m_axi_rid;
      r_data_d = m_axi_rdata;
      r_resp_d = m_axi_rresp;
      r_last_d = m_axi_rlast;
    end else begin
      r_id_d   = r_id_q;
      r_data_d = r_data_q;
      r_resp_d = r_resp_q;
      r_last_d = r_last_q;
    end
  end

  // R control state; reset empties the buffer, leaving stale payload behind.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state_q <= ST_IDLE;
      r_cnt_q   <= {R_CW{1'b0}};
    end else begin
      r_state_q <= r_state_d;
      r_cnt_q   <= r_cnt_d;
    end
  end

  // R payload storage, validity is tracked by r_state_q alone.
  always_ff @(posedge clock) begin
    r_id_q   <= r_id_d;
    r_data_q <= r_data_d;
    r_resp_q <= r_resp_d;
    r_last_q <= r_last_d;
  end

  // B: same one-entry buffer scheme as R, for write responses.
  always_comb begin
    b_state_d    = b_state_q;
    b_cnt_d      = b_cnt_q;
    b_load_s     = 1'b0;
    s_axi_bvalid = 1'b0;
    m_axi_bready = 1'b0;
    case (b_state_q)
      ST_IDLE: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) begin
          b_load_s  = 1'b1;
          b_state_d = ST_WAIT;
          b_cnt_d   = {B_CW{1'b0}};
        end else begin
          b_state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!b_stall || (b_cnt_q == B_MAX_C)) begin
          s_axi_bvalid = 1'b1;
          b_state_d    = s_axi_bready ? ST_IDLE : ST_SHOW;
        end else begin
          b_cnt_d = (b_cnt_q == B_MAX_C) ? b_cnt_q : b_cnt_q + B_ONE_C;
        end
      end
      ST_SHOW: begin
        s_axi_bvalid = 1'b1;
        m_axi_bready = s_axi_bready;
        if (s_axi_bready && m_axi_bvalid) begin
          b_load_s  = 1'b1;
          b_state_d = ST_WAIT;
          b_cnt_d   = {B_CW{1'b0}};
        end else if (s_axi_bready) begin
          b_state_d = ST_IDLE;
        end else begin
          b_state_d = ST_SHOW;
        end
      end
      default: begin
        b_state_d = ST_IDLE;
      end
    endcase
  end

  // B payload next value: refreshed only on capture.
  always_comb begin
    if (b_load_s) begin
      b_id_d   = m_axi_bid;
      b_resp_d = m_axi_bresp;
    end else begin
      b_id_d   = b_id_q;
      b_resp_d = b_resp_q;
    end
  end

  // B control state.
  always_ff @(posedge clock) begin
    if (reset) begin
      b_state_q <= ST_IDLE;
      b_cnt_q   <= {B_CW{1'b0}};
    end else begin
      b_state_q <= b_state_d;
      b_cnt_q   <= b_cnt_d;
    end
  end

  // B payload storage.
  always_ff @(posedge clock) begin
    b_id_q   <= b_id_d;
    b_resp_q <= b_resp_d;
  end

endmodule
